mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/addsub_33.sv | 12 +
 rtl/mult_div.sv | 150 +++++++++++++++
 tb/tb_mult_div.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared constants, state encoding and helpers for the multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CW    = 5;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

  // Unsigned magnitude of a two's complement word; 0x80000000 maps to 2^31.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/addsub_33.sv
// 33-bit adder/subtractor shared by the Booth and non-restoring datapaths.
module addsub_33 (
  input  logic [32:0] a,
  input  logic [32:0] b,
  input  logic        sub,
  output logic [32:0] sum
);

  // Subtract as a + ~b + 1.
  assign sum = a + (b ^ {33{sub}}) + {32'd0, sub};

endmodule

// File: rtl/mult_div.sv
// Iterative 32-bit signed multiply (radix-2 Booth) and divide (non-restoring).
// 33-cycle latency from start to a one-cycle data_resultRDY pulse.
module mult_div
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_e           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;    // Booth upper accumulator / partial remainder
  logic [WIDTH:0]   m;      // multiplicand (sign-extended) / divisor magnitude
  logic [WIDTH-1:0] q;      // multiplier -> product low / dividend -> quotient
  logic             qm1;
  logic             op_div, neg, dz, ovf;

  logic [WIDTH:0]   add_a, add_b, sum;
  logic             add_sub;
  logic             start, last;
  logic [WIDTH-1:0] res_c;
  logic             exc_c;

  assign start = ctrl_MULT | ctrl_DIV;
  assign last  = (count == CW'(ITER - 1));

  addsub_33 u_addsub (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum)
  );

  // Adder operand steering: Booth recode for multiply, sign-driven add/sub for divide.
  always_comb begin
    add_a   = acc;
    add_b   = m;
    add_sub = 1'b0;
    if (state == DIV) begin
      add_a   = {acc[WIDTH-1:0], q[WIDTH-1]};
      add_sub = ~acc[WIDTH];
    end else begin
      case ({q[0], qm1})
        2'b01:   add_sub = 1'b0;
        2'b10:   add_sub = 1'b1;
        default: add_b   = '0;
      endcase
    end
  end

  // Next state: any start pulse (multiply first) overrides the current state.
  always_comb begin
    state_next = state;
    if (ctrl_MULT) begin
      state_next = MULT;
    end else if (ctrl_DIV) begin
      state_next = DIV;
    end else begin
      case (state)
        MULT, DIV: if (last) state_next = DONE;
        DONE:      state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Final result and exception from the finished datapath.
  always_comb begin
    res_c = q;
    exc_c = (acc[WIDTH-1:0] != {WIDTH{q[WIDTH-1]}});
    if (op_div) begin
      exc_c = dz | ovf;
      if (dz) begin
        res_c = '0;
      end else if (neg) begin
        res_c = ~q + WIDTH'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath iteration, operand capture and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count          <= '0;
      acc            <= '0;
      m              <= '0;
      q              <= '0;
      qm1            <= 1'b0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      ovf            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        count  <= '0;
        acc    <= '0;
        qm1    <= 1'b0;
        op_div <= ~ctrl_MULT;
        neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz     <= (data_operandB == '0);
        ovf    <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
        if (ctrl_MULT) begin
          m <= {data_operandA[WIDTH-1], data_operandA};
          q <= data_operandB;
        end else begin
          m <= {1'b0, magnitude(data_operandB)};
          q <= magnitude(data_operandA);
        end
      end else begin
        case (state)
          MULT: begin
            acc <= {sum[WIDTH], sum[WIDTH:1]};
            q   <= {sum[0], q[WIDTH-1:1]};
            qm1 <= q[0];
            if (!last) count <= count + CW'(1);
          end
          DIV: begin
            acc <= sum;
            q   <= {q[WIDTH-2:0], ~sum[WIDTH]};
            if (!last) count <= count + CW'(1);
          end
          DONE: begin
            data_result    <= res_c;
            data_exception <= exc_c;
            data_resultRDY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// Directed self-checking bench for mult_div.
module tb_mult_div;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int errors = 0;
  int checks = 0;

  mult_div dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Start an operation (sampled at edge k), scramble operands afterwards, and
  // report what is seen up to edge k+34. Inputs change on falling edges.
  task automatic run_op(input logic mul, input logic dv, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] res, output logic exc,
                        output int early, output logic rdy_at, output logic rdy_after);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = mul;
    ctrl_DIV = dv;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    early = 0;
    repeat (32) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    @(negedge clock);
    rdy_at = data_resultRDY;
    res = data_result;
    exc = data_exception;
    @(negedge clock);
    rdy_after = data_resultRDY;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if (data_result !== 32'h0) begin
      errors++;
      $display("FAIL reset data_result: got %h expected 00000000", data_result);
    end
    checks++;
    if (data_exception !== 1'b0) begin
      errors++;
      $display("FAIL reset data_exception: got %b expected 0", data_exception);
    end
    checks++;
    if (data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset data_resultRDY: got %b expected 0", data_resultRDY);
    end
    reset = 1'b0;
  endtask

  // Shared by multiply/divide vector tests: all outcomes compared inline.
  task automatic test_vectors(input string name, input logic mul, input logic [31:0] va[4],
                              input logic [31:0] vb[4], input logic [31:0] vr[4],
                              input logic ve[4]);
    logic [31:0] res;
    logic exc, rdy_at, rdy_after;
    int early;
    for (int i = 0; i < 4; i++) begin
      run_op(mul, ~mul, va[i], vb[i], res, exc, early, rdy_at, rdy_after);
      checks++;
      if (res !== vr[i]) begin
        errors++;
        $display("FAIL %s[%0d] result: got %h expected %h", name, i, res, vr[i]);
      end
      checks++;
      if (exc !== ve[i]) begin
        errors++;
        $display("FAIL %s[%0d] exception: got %b expected %b", name, i, exc, ve[i]);
      end
      checks++;
      if (rdy_at !== 1'b1 || early != 0 || rdy_after !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d] rdy timing: got early=%0d at33=%b at34=%b expected 0 1 0",
                 name, i, early, rdy_at, rdy_after);
      end
    end
  endtask

  task automatic test_mult();
    logic [31:0] va[4] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[4] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] vr[4] = '{32'hFFFF_FFEB, 32'h0, 32'h8000_0000, 32'd1};
    logic        ve[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    test_vectors("mult", 1'b1, va, vb, vr, ve);
  endtask

  task automatic test_div();
    logic [31:0] va[4] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd20};
    logic [31:0] vb[4] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
    logic [31:0] vr[4] = '{32'hFFFF_FFFD, 32'h0, 32'h8000_0000, 32'hFFFF_FFFB};
    logic        ve[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    test_vectors("div", 1'b0, va, vb, vr, ve);
  endtask

  task automatic test_abort();
    int early = 0;
    @(negedge clock);
    data_operandA = 32'd20;
    data_operandB = 32'd4;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (9) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    data_operandA = 32'd1000;
    repeat (32) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    @(negedge clock);
    checks++;
    if (data_resultRDY !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL abort rdy: got early=%0d at43=%b expected 0 1", early, data_resultRDY);
    end
    checks++;
    if (data_result !== 32'd42 || data_exception !== 1'b0) begin
      errors++;
      $display("FAIL abort result: got %h/%b expected 0000002a/0", data_result,
               data_exception);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    logic exc, rdy_at, rdy_after;
    int early = 0;
    @(negedge clock);
    data_operandA = 32'h1234;
    data_operandB = 32'h10;
    ctrl_MULT = 1'b1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    repeat (14) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_result !== 32'h0 || data_exception !== 1'b0 || data_resultRDY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid outputs: got %h/%b/%b expected 00000000/0/0", data_result,
               data_exception, data_resultRDY);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL reset_mid stray rdy: got %0d pulses expected 0", early);
    end
    run_op(1'b1, 1'b0, 32'd5, 32'd5, res, exc, early, rdy_at, rdy_after);
    checks++;
    if (res !== 32'd25 || exc !== 1'b0 || rdy_at !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL reset_mid 5x5: got %h/%b rdy=%b early=%0d expected 00000019/0 1 0",
               res, exc, rdy_at, early);
    end
  endtask

  task automatic test_both();
    logic [31:0] res;
    logic exc, rdy_at, rdy_after;
    int early;
    run_op(1'b1, 1'b1, 32'd9, 32'd3, res, exc, early, rdy_at, rdy_after);
    checks++;
    if (res !== 32'd27 || exc !== 1'b0 || rdy_at !== 1'b1 || early != 0) begin
      errors++;
      $display("FAIL both result: got %h/%b rdy=%b early=%0d expected 0000001b/0 1 0",
               res, exc, rdy_at, early);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_reset_mid();
    test_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
